// File: rtl/decode_ctrl_stage_if.sv
// decode_ctrl_stage_if: fetch-side handshake plus the registered control bundle handed to EX.
interface decode_ctrl_stage_if #(parameter int XLEN = 32, parameter int ALU_CTRL_W = 5);
    logic                  in_valid, in_ready, flush, ex_ready, out_valid;
    logic [31:0]           instr;
    logic [XLEN-1:0]       pc_in, imm, pc_out;
    logic [ALU_CTRL_W-1:0] ALU_ctrl;
    logic                  ALU_src, MEM_wen, WB_sel, Reg_WB, branch, jump, jalr, auipc, illegal;
    logic [2:0]            mem_size;
    logic [4:0]            rs1, rs2, rd;
    modport slave (
        input  in_valid, instr, pc_in, flush, ex_ready,
        output in_ready, out_valid, ALU_ctrl, ALU_src, MEM_wen, WB_sel, Reg_WB, branch, jump,
               jalr, auipc, mem_size, rs1, rs2, rd, imm, pc_out, illegal
    );
    modport master (
        output in_valid, instr, pc_in, flush, ex_ready,
        input  in_ready, out_valid, ALU_ctrl, ALU_src, MEM_wen, WB_sel, Reg_WB, branch, jump,
               jalr, auipc, mem_size, rs1, rs2, rd, imm, pc_out, illegal
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32I ID/EX decode with valid/ready handshakes,
// one-bubble load-use interlock and branch-resolve flush.
module decode_ctrl_stage #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 5,
    parameter bit HAZARD_EN  = 1'b1
) (
    input logic              clk,
    input logic              reset,
    decode_ctrl_stage_if.slave bus
);
    logic [31:0]     i;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      op;
    logic [XLEN-1:0] imm_d;
    logic            src, wen, wbs, rwb, br, jmp, jr, aui, bad, use1, use2, is_mem;
    logic            adv, hazard;

    function automatic logic [4:0] alu_op(input logic [2:0] f, input logic alt);
        case (f)
            3'd0:    return alt ? 5'h01 : 5'h00;
            3'd1:    return 5'h05;
            3'd2:    return 5'h09;
            3'd3:    return 5'h0C;
            3'd4:    return 5'h02;
            3'd5:    return alt ? 5'h0A : 5'h06;
            3'd6:    return 5'h03;
            default: return 5'h04;
        endcase
    endfunction

    function automatic logic [4:0] br_op(input logic [2:0] f);
        case (f)
            3'd0:    return 5'h07;
            3'd1:    return 5'h08;
            3'd4:    return 5'h0D;
            3'd5:    return 5'h0E;
            3'd6:    return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    assign i   = bus.instr;
    assign opc = i[6:0];
    assign f3  = i[14:12];
    assign f7  = i[31:25];

    always_comb begin
        op = 5'h00; src = 1'b0; wen = 1'b0; wbs = 1'b0; rwb = 1'b0; br = 1'b0; jmp = 1'b0;
        jr = 1'b0; aui = 1'b0; bad = 1'b0; use1 = 1'b0; use2 = 1'b0; is_mem = 1'b0; imm_d = '0;
        case (opc)
            7'b0110011: begin
                rwb = 1'b1; use1 = 1'b1; use2 = 1'b1;
                op  = alu_op(f3, f7[5]);
                bad = f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'b0010011: begin
                rwb = 1'b1; use1 = 1'b1; src = 1'b1;
                op  = alu_op(f3, f7[5] && f3 == 3'd5);
                imm_d = (f3 == 3'd1 || f3 == 3'd5) ? XLEN'(i[24:20]) : XLEN'($signed(i[31:20]));
                bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'b0000011: begin
                rwb = 1'b1; wbs = 1'b1; use1 = 1'b1; src = 1'b1; is_mem = 1'b1;
                imm_d = XLEN'($signed(i[31:20]));
                bad = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
            end
            7'b0100011: begin
                wen = 1'b1; use1 = 1'b1; use2 = 1'b1; src = 1'b1; is_mem = 1'b1;
                imm_d = XLEN'($signed({i[31:25], i[11:7]}));
                bad = f3 > 3'd2;
            end
            7'b1100011: begin
                br = 1'b1; use1 = 1'b1; use2 = 1'b1;
                op = br_op(f3);
                imm_d = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
                bad = f3 == 3'd2 || f3 == 3'd3;
            end
            7'b1101111: begin
                rwb = 1'b1; jmp = 1'b1; src = 1'b1;
                imm_d = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'b1100111: begin
                rwb = 1'b1; jmp = 1'b1; jr = 1'b1; use1 = 1'b1; src = 1'b1;
                imm_d = XLEN'($signed(i[31:20]));
                bad = f3 != 3'd0;
            end
            7'b0110111: begin
                rwb = 1'b1; src = 1'b1; op = 5'h11;
                imm_d = XLEN'($signed({i[31:12], 12'b0}));
            end
            7'b0010111: begin
                rwb = 1'b1; src = 1'b1; aui = 1'b1; op = 5'h0B;
                imm_d = XLEN'($signed({i[31:12], 12'b0}));
            end
            default: bad = 1'b1;
        endcase
        // an illegal word must never commit architectural state or redirect fetch
        if (bad) begin
            rwb = 1'b0; wen = 1'b0; br = 1'b0; jmp = 1'b0; jr = 1'b0; wbs = 1'b0;
        end
    end

    assign adv    = !bus.out_valid || bus.ex_ready;
    assign hazard = HAZARD_EN && bus.out_valid && bus.WB_sel && bus.rd != 5'd0 && bus.in_valid &&
                    ((use1 && i[19:15] == bus.rd) || (use2 && i[24:20] == bus.rd));
    assign bus.in_ready = bus.flush || (adv && !hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.ALU_ctrl  <= '0;
            bus.ALU_src   <= 1'b0;
            bus.MEM_wen   <= 1'b0;
            bus.WB_sel    <= 1'b0;
            bus.Reg_WB    <= 1'b0;
            bus.branch    <= 1'b0;
            bus.jump      <= 1'b0;
            bus.jalr      <= 1'b0;
            bus.auipc     <= 1'b0;
            bus.mem_size  <= 3'd0;
            bus.rs1       <= 5'd0;
            bus.rs2       <= 5'd0;
            bus.rd        <= 5'd0;
            bus.imm       <= '0;
            bus.pc_out    <= '0;
            bus.illegal   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= bus.in_valid && !hazard;
            if (bus.in_valid && !hazard) begin
                bus.ALU_ctrl <= ALU_CTRL_W'(op);
                bus.ALU_src  <= src;
                bus.MEM_wen  <= wen;
                bus.WB_sel   <= wbs;
                bus.Reg_WB   <= rwb;
                bus.branch   <= br;
                bus.jump     <= jmp;
                bus.jalr     <= jr;
                bus.auipc    <= aui;
                bus.mem_size <= is_mem ? f3 : 3'd0;
                bus.rs1      <= i[19:15];
                bus.rs2      <= i[24:20];
                bus.rd       <= i[11:7];
                bus.imm      <= imm_d;
                bus.pc_out   <= bus.pc_in;
                bus.illegal  <= bad;
            end
        end
    end
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed decode, hazard, stall, flush, illegal and reset vectors
// with hand-computed expectations.
module tb_decode_ctrl_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    decode_ctrl_stage_if #(.XLEN(32), .ALU_CTRL_W(5)) bus ();

    decode_ctrl_stage #(.XLEN(32), .ALU_CTRL_W(5), .HAZARD_EN(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.instr    = w;
        bus.pc_in    = pc;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.instr = 32'h0; bus.pc_in = 32'h0;
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_regwb", 32'(bus.Reg_WB), 32'd0);
        chk("rst_imm", bus.imm, 32'd0);
        chk("rst_rd", 32'(bus.rd), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        offer(32'h002081B3, 32'h100);        // add x3,x1,x2
        step();
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_alu", 32'(bus.ALU_ctrl), 32'h0);
        chk("add_regwb", 32'(bus.Reg_WB), 32'd1);
        chk("add_rd", 32'(bus.rd), 32'd3);
        chk("add_rs1", 32'(bus.rs1), 32'd1);
        chk("add_rs2", 32'(bus.rs2), 32'd2);
        chk("add_pc", bus.pc_out, 32'h100);
        chk("add_src", 32'(bus.ALU_src), 32'd0);

        offer(32'h402081B3, 32'h104);        // sub
        step();
        chk("sub_alu", 32'(bus.ALU_ctrl), 32'h1);

        offer(32'h4040D193, 32'h108);        // srai x3,x1,4
        step();
        chk("srai_alu", 32'(bus.ALU_ctrl), 32'hA);
        chk("srai_src", 32'(bus.ALU_src), 32'd1);
        chk("srai_imm", bus.imm, 32'd4);

        offer(32'hFFF00093, 32'h10C);        // addi x1,x0,-1
        step();
        chk("addi_alu", 32'(bus.ALU_ctrl), 32'h0);
        chk("addi_imm", bus.imm, 32'hFFFFFFFF);

        offer(32'h0000A283, 32'h110);        // lw x5,0(x1)
        step();
        chk("lw_wbsel", 32'(bus.WB_sel), 32'd1);
        chk("lw_rd", 32'(bus.rd), 32'd5);
        chk("lw_size", 32'(bus.mem_size), 32'd2);
        offer(32'h00528333, 32'h114);        // add x6,x5,x5 depends on the load
        #1;
        chk("hz_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("hz_bubble", 32'(bus.out_valid), 32'd0);
        chk("hz_clear", 32'(bus.in_ready), 32'd1);
        step();
        chk("hz_issue_valid", 32'(bus.out_valid), 32'd1);
        chk("hz_issue_rd", 32'(bus.rd), 32'd6);
        chk("hz_issue_pc", bus.pc_out, 32'h114);

        offer(32'h00208463, 32'h118);        // beq x1,x2,+8
        step();
        chk("beq_branch", 32'(bus.branch), 32'd1);
        chk("beq_alu", 32'(bus.ALU_ctrl), 32'h7);
        chk("beq_imm", bus.imm, 32'd8);
        chk("beq_regwb", 32'(bus.Reg_WB), 32'd0);

        offer(32'h123453B7, 32'h11C);        // lui x7,0x12345
        step();
        chk("lui_imm", bus.imm, 32'h12345000);
        chk("lui_alu", 32'(bus.ALU_ctrl), 32'h11);
        chk("lui_rd", 32'(bus.rd), 32'd7);

        offer(32'h0020A223, 32'h120);        // sw x2,4(x1)
        step();
        chk("sw_wen", 32'(bus.MEM_wen), 32'd1);
        chk("sw_imm", bus.imm, 32'd4);
        chk("sw_regwb", 32'(bus.Reg_WB), 32'd0);

        offer(32'h002081B3, 32'h200);        // add, then stall EX
        step();
        bus.ex_ready = 1'b0;
        offer(32'h402081B3, 32'h204);
        #1;
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_alu", 32'(bus.ALU_ctrl), 32'h0);
        chk("stall_pc", bus.pc_out, 32'h200);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.flush = 1'b0;
        #1;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("post_flush_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("post_flush_valid", 32'(bus.out_valid), 32'd1);
        chk("post_flush_alu", 32'(bus.ALU_ctrl), 32'h1);
        bus.ex_ready = 1'b1;

        offer(32'h0000007F, 32'h300);        // unknown opcode
        step();
        chk("ill_valid", 32'(bus.out_valid), 32'd1);
        chk("ill_flag", 32'(bus.illegal), 32'd1);
        chk("ill_regwb", 32'(bus.Reg_WB), 32'd0);
        chk("ill_wen", 32'(bus.MEM_wen), 32'd0);

        offer(32'h002081B3, 32'h304);
        step();
        chk("legal_again", 32'(bus.illegal), 32'd0);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_rd", 32'(bus.rd), 32'd0);
        chk("mid_rst_regwb", 32'(bus.Reg_WB), 32'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("idle_valid", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
